// File: rtl/nibble_add_pkg.sv
// Shared types and helpers for the nibble-serial adder controller and its 4-bit slice.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Words up to 16 nibbles are handled by zero-extending to 64 bits at the call site.
  function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [63:0] word, input int k);
    return word[k*NIBBLE_W +: NIBBLE_W];
  endfunction

  // One-bit full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit ripple-carry adder slice, one full-adder cell per bit.
module nibble_adder_slice
  import nibble_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign {c[i+1], s[i]} = full_add(x[i], y[i], c[i]);
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder that time-shares one 4-bit slice, one nibble per cycle, LSB first.
// Define NIBBLE_SERIAL_SUB_EN to add a 'sub' input selecting A - B.
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                    cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic                    sub,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                    cout
);

  localparam int W = NIBBLE_W * NIBBLES;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic                carry_q;
  logic [W-1:0]        a_q, b_q, partial_q, sum_q;
  logic                cout_q;

  logic [NIBBLE_W-1:0] slice_x, slice_y, slice_s;
  logic                slice_co;
  logic [W-1:0]        partial_upd;
  logic                last_nibble;

  assign slice_x     = nibble_of(64'(a_q), int'(idx));
  assign slice_y     = nibble_of(64'(b_q), int'(idx));
  assign last_nibble = (idx == IDX_W'(NIBBLES - 1));

  nibble_adder_slice u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // The final nibble is merged here so sum can load the complete result in one step.
  always_comb begin
    partial_upd = partial_q;
    partial_upd[int'(idx)*NIBBLE_W +: NIBBLE_W] = slice_s;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_nibble) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      partial_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            idx <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
            // Subtraction as A + ~B + 1: invert B once here and seed the carry.
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
`else
            b_q     <= b;
            carry_q <= cin;
`endif
          end
        end
        RUN: begin
          partial_q <= partial_upd;
          carry_q   <= slice_co;
          if (last_nibble) begin
            sum_q  <= partial_upd;
            cout_q <= slice_co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
